// File: rtl/flip_pkg.sv
// Shared definitions for the flip sequencer: sequencer state encoding and
// default lane geometry.
package flip_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned WORD_BYTES_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_RD,
      WAIT_RD,
      ISSUE_WR,
      WAIT_WR,
      NEXT,
      FINISH
   } state_t;

endpackage

// File: rtl/flip_sequencer_word_flip.sv
// Combinational word flip: byte-lane reversal, plus bit reversal inside each
// lane when FLIP_BITREV_EN is defined.
module word_flip #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned WORD_BYTES = 2
) (
   input  logic [WORD_BYTES*DATA_WIDTH-1:0] din,
   output logic [WORD_BYTES*DATA_WIDTH-1:0] dout
);

   for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
      for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
`ifdef FLIP_BITREV_EN
         assign dout[i*DATA_WIDTH + b] =
            din[(WORD_BYTES-1-i)*DATA_WIDTH + (DATA_WIDTH-1-b)];
`else
         assign dout[i*DATA_WIDTH + b] = din[(WORD_BYTES-1-i)*DATA_WIDTH + b];
`endif
      end
   end

endmodule

// File: rtl/flip_sequencer.sv
// Block flip sequencer: reads words through an adapter, flips them with
// word_flip and writes them back in place. FLIP_BITREV_EN adds bit reversal.
module flip_sequencer
   import flip_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned WORD_BYTES = WORD_BYTES_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [7:0]                       start_addr,
   input  logic [7:0]                       num_words,
   output logic                             busy,
   output logic                             done,
   output logic [7:0]                       words_done,
   output logic                             st_read,
   output logic                             st_write,
   output logic [7:0]                       base_addr,
   output logic [WORD_BYTES*DATA_WIDTH-1:0] write_data,
   input  logic [WORD_BYTES*DATA_WIDTH-1:0] read_data,
   input  logic                             flip_ready,
   input  logic                             wrt_done
);

   localparam int unsigned WW        = WORD_BYTES*DATA_WIDTH;
   localparam logic [7:0]  ADDR_STEP = 8'(WORD_BYTES);

   state_t          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            st_read_q, st_read_d;
   logic            st_write_q, st_write_d;
   logic [7:0]      base_addr_q, base_addr_d;
   logic [7:0]      words_done_q, words_done_d;
   logic [7:0]      remaining_q, remaining_d;
   logic [WW-1:0]   word_q, word_d;

   // Request strobes are raised on the transition into the issue states so
   // the registered strobe coincides exactly with ISSUE_RD / ISSUE_WR.
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      st_read_d    = 1'b0;
      st_write_d   = 1'b0;
      base_addr_d  = base_addr_q;
      words_done_d = words_done_q;
      remaining_d  = remaining_q;
      word_d       = word_q;
      unique case (state_q)
         IDLE: begin
            if (start && !busy_q) begin
               base_addr_d  = start_addr;
               remaining_d  = num_words;
               words_done_d = '0;
               busy_d       = 1'b1;
               if (num_words == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d   = ISSUE_RD;
                  st_read_d = 1'b1;
               end
            end
         end
         ISSUE_RD: state_d = WAIT_RD;
         WAIT_RD: begin
            if (flip_ready) begin
               word_d     = read_data;
               state_d    = ISSUE_WR;
               st_write_d = 1'b1;
            end
         end
         ISSUE_WR: state_d = WAIT_WR;
         WAIT_WR: begin
            if (wrt_done) state_d = NEXT;
         end
         NEXT: begin
            words_done_d = words_done_q + 8'd1;
            remaining_d  = remaining_q - 8'd1;
            base_addr_d  = base_addr_q + ADDR_STEP;
            if (remaining_q != 8'd1) begin
               state_d   = ISSUE_RD;
               st_read_d = 1'b1;
            end else begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         st_read_q    <= 1'b0;
         st_write_q   <= 1'b0;
         base_addr_q  <= '0;
         words_done_q <= '0;
         remaining_q  <= '0;
         word_q       <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         st_read_q    <= st_read_d;
         st_write_q   <= st_write_d;
         base_addr_q  <= base_addr_d;
         words_done_q <= words_done_d;
         remaining_q  <= remaining_d;
         word_q       <= word_d;
      end
   end

   // word_q only loads in WAIT_RD, so write_data is stable through WAIT_WR.
   word_flip #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_BYTES (WORD_BYTES)
   ) u_word_flip (
      .din  (word_q),
      .dout (write_data)
   );

   assign busy       = busy_q;
   assign done       = done_q;
   assign st_read    = st_read_q;
   assign st_write   = st_write_q;
   assign base_addr  = base_addr_q;
   assign words_done = words_done_q;

endmodule

// File: tb/tb_flip_sequencer.sv
// Directed bench for flip_sequencer with a behavioural adapter; honours
// FLIP_BITREV_EN when the same define is given to the build.
module tb_flip_sequencer;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  n;
      logic [15:0] seed;
      logic [15:0] exp0;
      int          rd_lat;
      int          wr_lat;
   } job_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_addr = '0;
   logic [7:0]  num_words = '0;
   logic        busy, done, st_read, st_write;
   logic [7:0]  words_done, base_addr;
   logic [15:0] write_data;
   logic [15:0] read_data = '0;
   logic        flip_ready = 1'b0;
   logic        wrt_done = 1'b0;

   int   errors = 0;
   int   checks = 0;
   int   n_reads = 0;
   int   n_writes = 0;
   int   n_done = 0;
   int   rd_cnt = 0;
   int   wr_cnt = 0;
   logic noise = 1'b0;
   logic [15:0] exp_w = '0;
   job_t cur;
   job_t jobs[5];

   flip_sequencer #(
      .DATA_WIDTH (8),
      .WORD_BYTES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .num_words  (num_words),
      .busy       (busy),
      .done       (done),
      .words_done (words_done),
      .st_read    (st_read),
      .st_write   (st_write),
      .base_addr  (base_addr),
      .write_data (write_data),
      .read_data  (read_data),
      .flip_ready (flip_ready),
      .wrt_done   (wrt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] flip_ref(input logic [15:0] d);
      logic [15:0] r;
`ifdef FLIP_BITREV_EN
      for (int i = 0; i < 16; i++) r[i] = d[15-i];
`else
      r = {d[7:0], d[15:8]};
`endif
      return r;
   endfunction

   function automatic logic [7:0] exp_addr(input int k);
      return 8'(cur.addr + 8'(2*k));
   endfunction

   // Adapter model: answers each request after a per-job latency.
   always @(negedge clk) begin
      flip_ready = noise;
      wrt_done   = noise;
      if (!rst_n) begin
         rd_cnt = 0;
         wr_cnt = 0;
      end else begin
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               flip_ready = 1'b1;
               read_data  = cur.seed + 16'(n_reads - 1);
            end
         end
         if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) begin
               wrt_done = 1'b1;
               chk("wdata_hold", {16'h0, write_data}, {16'h0, exp_w});
               chk("addr_hold", {24'h0, base_addr}, {24'h0, exp_addr(n_writes - 1)});
            end
         end
         if (st_read || st_write)
            chk("rd_wr_excl", {31'h0, st_read & st_write}, 32'h0);
         if (st_read) begin
            chk("rd_addr", {24'h0, base_addr}, {24'h0, exp_addr(n_reads)});
            n_reads++;
            rd_cnt = cur.rd_lat;
         end
         if (st_write) begin
            exp_w = (n_writes == 0) ? cur.exp0 : flip_ref(cur.seed + 16'(n_writes));
            chk("wr_data", {16'h0, write_data}, {16'h0, exp_w});
            chk("wr_addr", {24'h0, base_addr}, {24'h0, exp_addr(n_writes)});
            n_writes++;
            wr_cnt = cur.wr_lat;
         end
      end
      if (done) begin
         n_done++;
         chk("busy_low_at_done", {31'h0, busy}, 32'h0);
      end
   end

   task automatic kick(input job_t j);
      cur      = j;
      n_reads  = 0;
      n_writes = 0;
      n_done   = 0;
      @(negedge clk);
      start_addr = j.addr;
      num_words  = j.n;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'h0, busy}, 32'h1);
   endtask

   task automatic finish_check(input int n);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", {31'h0, seen}, 32'h1);
      repeat (3) @(negedge clk);
      chk("done_pulses", n_done, 1);
      chk("reads", n_reads, n);
      chk("writes", n_writes, n);
      chk("words_done", {24'h0, words_done}, n);
      chk("busy_idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_st_read"}, {31'h0, st_read}, 32'h0);
      chk({tag, "_st_write"}, {31'h0, st_write}, 32'h0);
      chk({tag, "_base_addr"}, {24'h0, base_addr}, 32'h0);
      chk({tag, "_words_done"}, {24'h0, words_done}, 32'h0);
      chk({tag, "_write_data"}, {16'h0, write_data}, 32'h0);
   endtask

   initial begin
      job_t j;
      logic seen;
`ifdef FLIP_BITREV_EN
      jobs[0] = '{8'h10, 8'd1, 16'hABCD, 16'hB3D5, 1, 1};
      jobs[1] = '{8'hFE, 8'd2, 16'h1234, 16'h2C48, 2, 3};
      jobs[2] = '{8'h40, 8'd0, 16'h0000, 16'h0000, 1, 1};
      jobs[3] = '{8'h20, 8'd1, 16'h0180, 16'h0180, 3, 1};
      jobs[4] = '{8'h80, 8'd4, 16'h00FF, 16'hFF00, 1, 2};
`else
      jobs[0] = '{8'h10, 8'd1, 16'hABCD, 16'hCDAB, 1, 1};
      jobs[1] = '{8'hFE, 8'd2, 16'h1234, 16'h3412, 2, 3};
      jobs[2] = '{8'h40, 8'd0, 16'h0000, 16'h0000, 1, 1};
      jobs[3] = '{8'h20, 8'd1, 16'h0180, 16'h8001, 3, 1};
      jobs[4] = '{8'h80, 8'd4, 16'h00FF, 16'hFF00, 1, 2};
`endif
      cur = jobs[0];

      // Start held during reset must not be taken.
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("no_start_in_reset", {31'h0, busy}, 32'h0);

      // Adapter flags outside the wait states are ignored.
      noise = 1'b1;
      repeat (5) @(negedge clk);
      noise = 1'b0;
      @(negedge clk);
      chk("noise_reads", n_reads, 0);
      chk("noise_writes", n_writes, 0);
      chk("noise_busy", {31'h0, busy}, 32'h0);

      for (int i = 0; i < 5; i++) begin
         kick(jobs[i]);
         finish_check(int'(jobs[i].n));
      end

      // Second start while busy must be ignored.
      j = '{8'h30, 8'd2, 16'h5566, flip_ref(16'h5566), 2, 2};
      kick(j);
      repeat (2) @(negedge clk);
      start_addr = 8'h90;
      num_words  = 8'd5;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_check(2);

      // Reset asserted while waiting for a write completion.
      j = '{8'h50, 8'd3, 16'h0F0F, flip_ref(16'h0F0F), 1, 20};
      kick(j);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (n_writes == 1) seen = 1'b1;
      end
      chk("reached_wait_wr", {31'h0, seen}, 32'h1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      kick(jobs[0]);
      finish_check(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
